ll_keydec: RTL and testbench

LL_KEYDEC -- requirements
Module: ll_keydec

---
 rtl/ll_pkg.sv | 26 ++
 rtl/bcdaddsub4.sv | 33 +++
 rtl/ll_keydec.sv | 104 ++++++++++
 tb/tb_ll_keydec.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared encodings for the lunar lander keypad decoder: display select codes,
// command key codes and key classification helpers.
package ll_pkg;

  localparam logic [1:0] SEL_THRUST = 2'd0;
  localparam logic [1:0] SEL_FUEL   = 2'd1;
  localparam logic [1:0] SEL_VEL    = 2'd2;
  localparam logic [1:0] SEL_ALT    = 2'd3;

  localparam logic [4:0] KEY_W = 5'd16;
  localparam logic [4:0] KEY_X = 5'd17;
  localparam logic [4:0] KEY_Y = 5'd18;
  localparam logic [4:0] KEY_Z = 5'd19;

  // Velocities at or above this BCD value are negative in 10's complement.
  localparam logic [15:0] BCD_NEG_MIN = 16'h5000;

  function automatic logic key_is_digit(input logic [4:0] k);
    return k <= 5'd9;
  endfunction

  function automatic logic key_is_cmd(input logic [4:0] k);
    return (k >= KEY_W) && (k <= KEY_Z);
  endfunction

endpackage

// File: rtl/bcdaddsub4.sv
// Four-digit BCD adder/subtractor: s = a + b (op=0) or a - b (op=1), 10's complement.
module bcdaddsub4 (
  input  logic        op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] s
);

  logic       c;
  logic [3:0] bd;
  logic [4:0] t;

  // Subtraction adds the 9's complement of b with a carry-in of one.
  always_comb begin
    c  = op;
    bd = 4'd0;
    t  = 5'd0;
    s  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      bd = b[4*i +: 4];
      if (op) bd = 4'd9 - bd;
      t = {1'b0, a[4*i +: 4]} + {1'b0, bd} + {4'b0000, c};
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
  end

endmodule

// File: rtl/ll_keydec.sv
// Lander keypad decoder: digit keys set thrust, W-Z pick the display quantity.
// Optional key holdoff window is enabled with KEYDEC_HOLDOFF_EN.
module ll_keydec
  import ll_pkg::*;
#(
  parameter logic [15:0] THRUST_INIT = 16'h0005,
  parameter int          HOLDOFF     = 8
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [4:0]  keycode,
  input  logic        keyclk,
  input  logic        frozen,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  output logic [15:0] thrust,
  output logic [1:0]  sel,
  output logic        key_evt,
  output logic [15:0] disp,
  output logic        disp_neg
);

  logic        keyclk_q, key_evt_q, disp_neg_q, disp_neg_d;
  logic [15:0] thrust_q, disp_q, disp_d, vel_neg;
  logic [1:0]  sel_q;
  logic        rise, accept, is_digit, is_cmd, key_ok;

  assign rise     = keyclk & ~keyclk_q;
  assign is_digit = key_is_digit(keycode);
  assign is_cmd   = key_is_cmd(keycode);
  assign key_ok   = is_digit | is_cmd;

`ifdef KEYDEC_HOLDOFF_EN
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  logic [HW-1:0] hold_q, hold_d;

  assign accept = rise & (hold_q == '0);

  always_comb begin
    hold_d = hold_q;
    if (accept & key_ok)    hold_d = HW'(HOLDOFF - 1);
    else if (hold_q != '0)  hold_d = hold_q - 1'b1;
  end

  always_ff @(posedge hz100) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign accept = rise;
`endif

  bcdaddsub4 u_neg (
    .op (1'b1),
    .a  (16'h0000),
    .b  (vel),
    .s  (vel_neg)
  );

  always_comb begin
    disp_d     = alt;
    disp_neg_d = 1'b0;
    case (sel_q)
      SEL_THRUST: disp_d = thrust_q;
      SEL_FUEL:   disp_d = fuel;
      SEL_VEL: begin
        if (vel >= BCD_NEG_MIN) begin
          disp_d     = vel_neg;
          disp_neg_d = 1'b1;
        end else begin
          disp_d = vel;
        end
      end
      default:    disp_d = alt;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (reset) begin
      // Tracking keyclk during reset means a key held through release gives no rise.
      keyclk_q   <= keyclk;
      key_evt_q  <= 1'b0;
      thrust_q   <= THRUST_INIT;
      sel_q      <= SEL_ALT;
      disp_q     <= 16'h0000;
      disp_neg_q <= 1'b0;
    end else begin
      keyclk_q   <= keyclk;
      key_evt_q  <= accept & key_ok;
      if (accept & is_digit & ~frozen) thrust_q <= {12'h000, keycode[3:0]};
      if (accept & is_cmd)             sel_q    <= keycode[1:0];
      disp_q     <= disp_d;
      disp_neg_q <= disp_neg_d;
    end
  end

  assign thrust   = thrust_q;
  assign sel      = sel_q;
  assign key_evt  = key_evt_q;
  assign disp     = disp_q;
  assign disp_neg = disp_neg_q;

endmodule

// File: tb/tb_ll_keydec.sv
// Directed bench for ll_keydec; holdoff expectations follow KEYDEC_HOLDOFF_EN.
module tb_ll_keydec;

  logic        hz100 = 1'b0;
  logic        reset, keyclk, frozen;
  logic [4:0]  keycode;
  logic [15:0] alt, vel, fuel;
  logic [15:0] thrust, disp;
  logic [1:0]  sel;
  logic        key_evt, disp_neg;

  int total = 0;
  int bad   = 0;

  ll_keydec #(.THRUST_INIT(16'h0005), .HOLDOFF(8)) dut (
    .hz100    (hz100),
    .reset    (reset),
    .keycode  (keycode),
    .keyclk   (keyclk),
    .frozen   (frozen),
    .alt      (alt),
    .vel      (vel),
    .fuel     (fuel),
    .thrust   (thrust),
    .sel      (sel),
    .key_evt  (key_evt),
    .disp     (disp),
    .disp_neg (disp_neg)
  );

  always #5 hz100 = ~hz100;

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    keycode = k;
    keyclk  = 1'b1;
    tick();
  endtask

  // Long enough gap that a holdoff window has always expired before the next press.
  task automatic rel();
    keyclk = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; keyclk = 1'b0; keycode = 5'd0; frozen = 1'b0;
    alt = 16'h1234; vel = 16'h0042; fuel = 16'h0567;
    tick(); tick();
    chk("rst_thrust", thrust, 16'h0005);
    chk("rst_sel", {14'd0, sel}, 16'd3);
    chk("rst_evt", {15'd0, key_evt}, 16'd0);
    chk("rst_disp", disp, 16'h0000);
    chk("rst_neg", {15'd0, disp_neg}, 16'd0);

    reset = 1'b0;
    tick();
    chk("disp_alt", disp, 16'h1234);
    chk("disp_alt_neg", {15'd0, disp_neg}, 16'd0);

    press(5'd7);
    chk("k7_thrust", thrust, 16'h0007);
    chk("k7_evt", {15'd0, key_evt}, 16'd1);
    tick();
    chk("k7_evt_one", {15'd0, key_evt}, 16'd0);
    rel();

    press(5'd5);
    chk("k5_thrust", thrust, 16'h0005);
    chk("k5_evt", {15'd0, key_evt}, 16'd1);
    keycode = 5'd2;
    n = 0;
    repeat (19) begin
      tick();
      if (key_evt) n++;
    end
    chk("hold_evts", 16'(n), 16'd0);
    chk("hold_thrust", thrust, 16'h0005);
    rel();

    vel = 16'h9970;
    press(5'd18);
    chk("y_sel", {14'd0, sel}, 16'd2);
    chk("y_evt", {15'd0, key_evt}, 16'd1);
    chk("y_disp_lat", disp, 16'h1234);
    tick();
    chk("vel_neg_disp", disp, 16'h0030);
    chk("vel_neg_flag", {15'd0, disp_neg}, 16'd1);
    rel();
    vel = 16'h4999; tick();
    chk("vel_4999", disp, 16'h4999);
    chk("vel_4999_neg", {15'd0, disp_neg}, 16'd0);
    vel = 16'h5000; tick();
    chk("vel_5000", disp, 16'h5000);
    chk("vel_5000_neg", {15'd0, disp_neg}, 16'd1);
    vel = 16'h0000; tick();
    chk("vel_0", disp, 16'h0000);
    chk("vel_0_neg", {15'd0, disp_neg}, 16'd0);

    press(5'd17);
    chk("x_sel", {14'd0, sel}, 16'd1);
    tick();
    chk("x_disp", disp, 16'h0567);
    rel();
    press(5'd16);
    chk("w_sel", {14'd0, sel}, 16'd0);
    tick();
    chk("w_disp", disp, 16'h0005);
    rel();

    frozen = 1'b1;
    press(5'd3);
    chk("frz_thrust", thrust, 16'h0005);
    chk("frz_evt", {15'd0, key_evt}, 16'd1);
    rel();
    press(5'd19);
    chk("frz_z_sel", {14'd0, sel}, 16'd3);
    rel();
    frozen = 1'b0;

    press(5'd12);
    chk("k12_evt", {15'd0, key_evt}, 16'd0);
    chk("k12_thrust", thrust, 16'h0005);
    chk("k12_sel", {14'd0, sel}, 16'd3);
    rel();
    press(5'd25);
    chk("k25_evt", {15'd0, key_evt}, 16'd0);
    rel();

    press(5'd8);
    chk("k8_thrust", thrust, 16'h0008);
    rel();
    reset = 1'b1; keycode = 5'd9; keyclk = 1'b1;
    tick();
    chk("rst_rise_thrust", thrust, 16'h0005);
    chk("rst_rise_evt", {15'd0, key_evt}, 16'd0);
    reset = 1'b0;
    tick();
    chk("held_rel_evt", {15'd0, key_evt}, 16'd0);
    chk("held_rel_thrust", thrust, 16'h0005);
    rel();
    press(5'd9);
    chk("k9_thrust", thrust, 16'h0009);
    chk("k9_evt", {15'd0, key_evt}, 16'd1);
    rel();

    press(5'd1);
    chk("ho_first", thrust, 16'h0001);
    keyclk = 1'b0;
    repeat (3) tick();
    keycode = 5'd2; keyclk = 1'b1;
    tick();
`ifdef KEYDEC_HOLDOFF_EN
    chk("ho_early_thrust", thrust, 16'h0001);
    chk("ho_early_evt", {15'd0, key_evt}, 16'd0);
`else
    chk("ho_early_thrust", thrust, 16'h0002);
    chk("ho_early_evt", {15'd0, key_evt}, 16'd1);
`endif
    keyclk = 1'b0;
    repeat (4) tick();
    keycode = 5'd3; keyclk = 1'b1;
    tick();
    chk("ho_late_thrust", thrust, 16'h0003);
    chk("ho_late_evt", {15'd0, key_evt}, 16'd1);
    keyclk = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
